// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- round-robin arbiter sharing one downstream resource among
// 16 requesters. The owner keeps the grant until it raises done or drops its
// request; every release is followed by one dead (GAP) cycle before the
// arbiter returns to IDLE and searches again.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   enable       permits new grants (never revokes an existing one)
//   req[15:0]    level-sensitive request lines
//   done         owner finished; only looked at while owning
//   grant[15:0]  registered one-hot grant, or zero
//   grant_id     binary index of the granted requester; holds when idle
//   grant_valid  high exactly when grant != 0
//   timeout      one-cycle pulse in the GAP cycle of a forced release
//
// Build option: define ARB_TIMEOUT_EN to add the hold counter and forced
// release after MAX_HOLD owning cycles. Without it timeout is tied to 0.
module rr_arbiter16 #(
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        grant_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n, gid_n;
  logic [15:0] grant_n;
  logic [3:0]  win, idx;
  logic        found;
  logic        hold_exp;
  logic        rel;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             to_n;
  assign hold_exp = (cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_exp = 1'b0;
  assign timeout  = 1'b0;
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD == CNT_W);
`endif

  assign grant_valid = |grant;

  // Search starts one past the last owner; the 4-bit add wraps 15 -> 0, and
  // k=16 lands back on ptr itself so a lone repeat requester still wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    gid_n   = grant_id;
    ptr_n   = ptr;
    rel     = done || !req[grant_id] || hold_exp;
`ifdef ARB_TIMEOUT_EN
    cnt_n   = cnt;
    to_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && found) begin
          grant_n = 16'd1 << win;
          gid_n   = win;
          state_n = OWN;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      OWN: begin
        if (rel) begin
          grant_n = '0;
          ptr_n   = grant_id;
          state_n = GAP;
`ifdef ARB_TIMEOUT_EN
          to_n    = hold_exp;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_n = cnt + 1'b1;
`endif
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= 4'hF;
`ifdef ARB_TIMEOUT_EN
      cnt      <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      grant_id <= gid_n;
      ptr      <= ptr_n;
`ifdef ARB_TIMEOUT_EN
      cnt      <= cnt_n;
      timeout  <= to_n;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16 -- directed bench for rr_arbiter16. Stimulus pushes the
// expected grant_id of each upcoming ownership into a queue; a negedge
// monitor pops and compares on every new grant and checks the output
// invariants every cycle.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        reset, enable, done;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid, timeout;

  always #5 clk = ~clk;

  rr_arbiter16 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid),
    .timeout(timeout)
  );

  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  logic prev_valid = 1'b0;
  int   low_run = 0;
  bit   chk_gap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for the current owner (if any) to go, then for the next grant.
  task automatic wait_new();
    int t = 0;
    while (grant_valid && t < 20) begin step(1); t++; end
    while (!grant_valid && t < 40) begin step(1); t++; end
    chk("wait_grant", {31'b0, grant_valid}, 32'd1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = grant_valid;
      low_run    = 0;
    end else begin
      int e;
      chk("valid_is_or", {31'b0, grant_valid}, {31'b0, |grant});
      chk("onehot0", {31'b0, $onehot0(grant)}, 32'd1);
      if (grant_valid) chk("grant_vs_id", {16'b0, grant}, {16'b0, 16'd1 << grant_id});
`ifndef ARB_TIMEOUT_EN
      chk("timeout_tied", {31'b0, timeout}, 32'd0);
`endif
      if (grant_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got id %0d expected none", grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id_seq", {28'b0, grant_id}, e);
        end
        if (chk_gap) chk("gap_len", low_run, 32'd2);
      end
      low_run    = grant_valid ? 0 : low_run + 1;
      prev_valid = grant_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; req = '0; done = 1'b0;
    step(2);
    chk("rst_grant", {16'b0, grant}, 32'd0);
    chk("rst_id", {28'b0, grant_id}, 32'd0);
    chk("rst_valid", {31'b0, grant_valid}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    reset = 1'b0;

    // 1: single requester, one-clock latency, release on req drop
    req = 16'h0001; enable = 1'b1; exp_q.push_back(0);
    step(1);
    chk("t1_grant", {16'b0, grant}, 32'h1);
    chk("t1_id", {28'b0, grant_id}, 32'd0);
    chk("t1_valid", {31'b0, grant_valid}, 32'd1);
    req = '0;
    step(1);
    chk("t1_release", {16'b0, grant}, 32'd0);
    step(1);
    chk("t1_idle", {16'b0, grant}, 32'd0);

    // 2: all requesting, done after each grant -> 0..15,0 with 2 dead cycles
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      wait_new();
      pulse_done();
      if (i == 0) chk_gap = 1'b1;
    end
    chk_gap = 1'b0;
    req = '0;
    step(3);

    // 3: wrap-around 14 -> 15 -> 0 -> 14
    do_reset();
    req = 16'h4000; exp_q.push_back(14);
    wait_new();
    req = 16'h8001; exp_q.push_back(15);
    wait_new();
    req = 16'hC001; exp_q.push_back(0);
    pulse_done();
    wait_new();
    exp_q.push_back(14);
    pulse_done();
    wait_new();
    pulse_done();
    req = '0;
    step(3);

    // 4: enable gates only new grants
    do_reset();
    enable = 1'b0; req = 16'h0100;
    step(10);
    chk("t4_blocked", {16'b0, grant}, 32'd0);
    enable = 1'b1; exp_q.push_back(8);
    step(1);
    chk("t4_grant", {16'b0, grant}, 32'h100);
    chk("t4_id", {28'b0, grant_id}, 32'd8);
    enable = 1'b0;
    step(5);
    chk("t4_held", {16'b0, grant}, 32'h100);
    pulse_done();
    chk("t4_released", {16'b0, grant}, 32'd0);
    chk("t4_id_kept", {28'b0, grant_id}, 32'd8);
    req = '0; enable = 1'b1;
    step(3);

    // 5: reset during ownership restores ptr=15
    do_reset();
    req = 16'h0020; exp_q.push_back(5);
    wait_new();
    step(2);
    reset = 1'b1;
    step(1);
    chk("t5_grant", {16'b0, grant}, 32'd0);
    chk("t5_id", {28'b0, grant_id}, 32'd0);
    chk("t5_valid", {31'b0, grant_valid}, 32'd0);
    reset = 1'b0; req = 16'h0021; exp_q.push_back(0);
    wait_new();
    chk("t5_regrant_id", {28'b0, grant_id}, 32'd0);
    pulse_done();
    req = '0;
    step(3);

`ifdef ARB_TIMEOUT_EN
    // 6: forced release after 4 owning cycles
    do_reset();
    req = 16'h0004; exp_q.push_back(2); exp_q.push_back(2);
    wait_new();
    begin
      int n = 0;
      while (grant_valid && n < 20) begin n++; step(1); end
      chk("t6_hold_len", n, 32'd4);
    end
    chk("t6_timeout_pulse", {31'b0, timeout}, 32'd1);
    step(1);
    chk("t6_timeout_clear", {31'b0, timeout}, 32'd0);
    step(1);
    chk("t6_regrant", {31'b0, grant_valid}, 32'd1);
    chk("t6_regrant_id", {28'b0, grant_id}, 32'd2);
    req = '0;
    step(3);
`endif

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
